// File: rtl/tlb_pkg.sv
// Shared types and widths for the joint-TLB search arbiter.
package tlb_pkg;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } tlb_arb_state_e;

  typedef enum logic [1:0] {
    OWN_I,
    OWN_D,
    OWN_P
  } tlb_owner_e;

  // Top 5 bits are reserved so the flattened entry is a round 64 bits.
  typedef struct packed {
    logic [4:0]        rsvd;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [19:0]       pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [19:0]       pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  localparam int ENTRY_W = $bits(tlb_entry_t);

endpackage

// File: rtl/tlb_search_arbiter_if.sv
// Request/response and TLB-array search signals around the arbiter.
interface tlb_search_arbiter_if;
  import tlb_pkg::*;

  logic              i_req;
  logic [VPN2_W-1:0] i_vpn2;
  logic              i_rsp_valid;
  logic              d_req;
  logic [VPN2_W-1:0] d_vpn2;
  logic              d_rsp_valid;
  logic              p_req;
  logic [VPN2_W-1:0] p_vpn2;
  logic              p_rsp_valid;
  logic [ASID_W-1:0] cp0_asid;
  logic              tlb_write;
  logic [VPN2_W-1:0] s_vpn2;
  logic [ASID_W-1:0] s_asid;
  logic              s_found;
  logic [IDX_W-1:0]  s_index;
  tlb_entry_t        s_entry;
  logic              rsp_found;
  logic [IDX_W-1:0]  rsp_index;
  tlb_entry_t        rsp_entry;
  logic              flush_ubuf;
  logic              busy;

  // Arbiter side
  modport slave (
    input  i_req, i_vpn2, d_req, d_vpn2, p_req, p_vpn2, cp0_asid, tlb_write,
           s_found, s_index, s_entry,
    output i_rsp_valid, d_rsp_valid, p_rsp_valid, s_vpn2, s_asid,
           rsp_found, rsp_index, rsp_entry, flush_ubuf, busy
  );

  // Requesters / TLB array side
  modport master (
    output i_req, i_vpn2, d_req, d_vpn2, p_req, p_vpn2, cp0_asid, tlb_write,
           s_found, s_index, s_entry,
    input  i_rsp_valid, d_rsp_valid, p_rsp_valid, s_vpn2, s_asid,
           rsp_found, rsp_index, rsp_entry, flush_ubuf, busy
  );

endinterface

// File: rtl/tlb_arb_pick.sv
// Winner select for the TLB search port: TLBP first, then I/D.
// TLB_ARB_RR_EN: round-robin between I and D; otherwise fixed P > D > I.
module tlb_arb_pick
  import tlb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       p_req,
  input  logic       grant,
  input  logic       done,
  input  tlb_owner_e done_owner,
  output tlb_owner_e winner,
  output logic       any_req
);

  assign any_req = i_req | d_req | p_req;

`ifdef TLB_ARB_RR_EN
  tlb_owner_e rr_last_q;
  logic       contend_q;

  // Only a completed search that won an I/D contention moves the pointer,
  // so a cancelled search or an uncontended grant leaves fairness untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= OWN_I;
      contend_q <= 1'b0;
    end else begin
      if (grant) begin
        contend_q <= i_req & d_req & ~p_req;
      end
      if (done && contend_q) begin
        rr_last_q <= done_owner;
      end
    end
  end

  always_comb begin
    winner = OWN_I;
    if (p_req) begin
      winner = OWN_P;
    end else if (i_req && d_req) begin
      winner = (rr_last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, clk, rst, grant, done, done_owner};

  always_comb begin
    winner = OWN_I;
    if (p_req) begin
      winner = OWN_P;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/tlb_search_arbiter.sv
// Shares the joint-TLB search port between I-miss, D-miss and TLBP.
// Optional macro TLB_ARB_RR_EN selects round-robin I/D arbitration.
module tlb_search_arbiter
  import tlb_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  tlb_search_arbiter_if.slave bus
);

  tlb_arb_state_e    state_q, state_d;
  tlb_owner_e        owner_q;
  tlb_owner_e        winner;
  logic              any_req;
  logic              grant;
  logic              capture;
  logic              cancel;
  logic              rsp_ok;
  logic [VPN2_W-1:0] vpn2_q, win_vpn2;
  logic [ASID_W-1:0] asid_q;
  logic              rsp_found_q;
  logic [IDX_W-1:0]  rsp_index_q;
  tlb_entry_t        rsp_entry_q;
  logic              flush_q;

  tlb_arb_pick u_pick (
    .clk        (clk),
    .rst        (rst),
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .p_req      (bus.p_req),
    .grant      (grant),
    .done       (rsp_ok && (owner_q != OWN_P)),
    .done_owner (owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    win_vpn2 = bus.i_vpn2;
    case (winner)
      OWN_D:   win_vpn2 = bus.d_vpn2;
      OWN_P:   win_vpn2 = bus.p_vpn2;
      default: win_vpn2 = bus.i_vpn2;
    endcase
  end

  // A TLB write invalidates any I/D lookup in flight; TLBP is ordered by CP0.
  assign cancel = bus.tlb_write && (owner_q != OWN_P);
  assign rsp_ok = (state_q == RESP) && !cancel;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req && !bus.tlb_write) begin
          grant   = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      vpn2_q      <= '0;
      asid_q      <= '0;
      rsp_found_q <= 1'b0;
      rsp_index_q <= '0;
      rsp_entry_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= bus.tlb_write;
      if (grant) begin
        owner_q <= winner;
        vpn2_q  <= win_vpn2;
        asid_q  <= bus.cp0_asid;
      end
      if (capture) begin
        rsp_found_q <= bus.s_found;
        rsp_index_q <= bus.s_index;
        rsp_entry_q <= bus.s_entry;
      end
    end
  end

  assign bus.s_vpn2      = vpn2_q;
  assign bus.s_asid      = asid_q;
  assign bus.i_rsp_valid = rsp_ok && (owner_q == OWN_I);
  assign bus.d_rsp_valid = rsp_ok && (owner_q == OWN_D);
  assign bus.p_rsp_valid = rsp_ok && (owner_q == OWN_P);
  assign bus.rsp_found   = rsp_found_q;
  assign bus.rsp_index   = rsp_index_q;
  assign bus.rsp_entry   = rsp_entry_q;
  assign bus.flush_ubuf  = flush_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Directed bench for tlb_search_arbiter with a small 16-entry TLB array model.
module tb_tlb_search_arbiter;
  import tlb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic              tb_vld  [16];
  logic [VPN2_W-1:0] tb_vpn2 [16];
  logic [63:0]       tb_ent  [16];

  localparam logic [63:0] E5  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] E9  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] E9B = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] E3  = 64'h5555_6666_7777_8888;

  tlb_search_arbiter_if bus ();

  tlb_search_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.s_found = 1'b0;
    bus.s_index = '0;
    bus.s_entry = '0;
    for (int k = 0; k < 16; k++) begin
      if (tb_vld[k] && (tb_vpn2[k] == bus.s_vpn2)) begin
        bus.s_found = 1'b1;
        bus.s_index = 4'(k);
        bus.s_entry = tb_ent[k];
      end
    end
  end

  // At most one response owner per cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ($onehot0({bus.i_rsp_valid, bus.d_rsp_valid, bus.p_rsp_valid}))
      else begin
        failures++;
        $error("FAIL onehot_rsp observed=%b expected=onehot0",
               {bus.i_rsp_valid, bus.d_rsp_valid, bus.p_rsp_valid});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_valids(input string tag, input logic [2:0] exp_idp);
    chk(tag, {61'b0, bus.i_rsp_valid, bus.d_rsp_valid, bus.p_rsp_valid}, {61'b0, exp_idp});
  endtask

  logic rr_i_first;

  initial begin
    checks   = 0;
    failures = 0;
`ifdef TLB_ARB_RR_EN
    rr_i_first = 1'b1;
`else
    rr_i_first = 1'b0;
`endif
    for (int k = 0; k < 16; k++) begin
      tb_vld[k]  = 1'b0;
      tb_vpn2[k] = '0;
      tb_ent[k]  = '0;
    end
    tb_vld[5] = 1'b1; tb_vpn2[5] = 19'h12345; tb_ent[5] = E5;
    tb_vld[9] = 1'b1; tb_vpn2[9] = 19'h0ABCD; tb_ent[9] = E9;
    tb_vld[3] = 1'b1; tb_vpn2[3] = 19'h00777; tb_ent[3] = E3;

    rst = 1'b1;
    bus.i_req = 0; bus.d_req = 0; bus.p_req = 0; bus.tlb_write = 0;
    bus.i_vpn2 = '0; bus.d_vpn2 = '0; bus.p_vpn2 = '0;
    bus.cp0_asid = 8'h3C;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk_valids("rst_valids", 3'b000);
    chk("rst_found", {63'b0, bus.rsp_found}, 64'd0);
    chk("rst_index", {60'b0, bus.rsp_index}, 64'd0);
    chk("rst_entry", bus.rsp_entry, 64'd0);
    chk("rst_s_vpn2", {45'b0, bus.s_vpn2}, 64'd0);
    chk("rst_s_asid", {56'b0, bus.s_asid}, 64'd0);
    chk("rst_flush", {63'b0, bus.flush_ubuf}, 64'd0);

    // Single I-side hit
    bus.i_req = 1; bus.i_vpn2 = 19'h12345;
    tick();
    chk("t1_c1_busy", {63'b0, bus.busy}, 64'd1);
    chk("t1_c1_s_vpn2", {45'b0, bus.s_vpn2}, 64'h12345);
    chk("t1_c1_s_asid", {56'b0, bus.s_asid}, 64'h3C);
    chk_valids("t1_c1_valids", 3'b000);
    tick();
    chk_valids("t1_c2_valids", 3'b100);
    chk("t1_c2_found", {63'b0, bus.rsp_found}, 64'd1);
    chk("t1_c2_index", {60'b0, bus.rsp_index}, 64'd5);
    chk("t1_c2_entry", bus.rsp_entry, E5);
    bus.i_req = 0;
    tick();
    chk("t1_c3_busy", {63'b0, bus.busy}, 64'd0);
    chk("t1_c3_s_vpn2_hold", {45'b0, bus.s_vpn2}, 64'h12345);

    // I/D contention, two rounds
    for (int r = 0; r < 2; r++) begin
      logic first_i;
      first_i = (r == 1) && rr_i_first;
      bus.i_req = 1; bus.i_vpn2 = 19'h12345;
      bus.d_req = 1; bus.d_vpn2 = 19'h0ABCD;
      tick();
      chk("t2_first_vpn2", {45'b0, bus.s_vpn2}, first_i ? 64'h12345 : 64'h0ABCD);
      tick();
      chk_valids("t2_first_valid", first_i ? 3'b100 : 3'b010);
      chk("t2_first_index", {60'b0, bus.rsp_index}, first_i ? 64'd5 : 64'd9);
      if (first_i) bus.i_req = 0; else bus.d_req = 0;
      tick();
      chk("t2_gap_busy", {63'b0, bus.busy}, 64'd0);
      tick();
      tick();
      chk_valids("t2_second_valid", first_i ? 3'b010 : 3'b100);
      chk("t2_second_index", {60'b0, bus.rsp_index}, first_i ? 64'd9 : 64'd5);
      bus.i_req = 0; bus.d_req = 0;
      tick();
    end

    // P, D and I together: TLBP first, then D, then I
    bus.p_req = 1; bus.p_vpn2 = 19'h00777;
    bus.d_req = 1; bus.d_vpn2 = 19'h0ABCD;
    bus.i_req = 1; bus.i_vpn2 = 19'h12345;
    tick();
    tick();
    chk_valids("t3_p_valid", 3'b001);
    chk("t3_p_index", {60'b0, bus.rsp_index}, 64'd3);
    chk("t3_p_entry", bus.rsp_entry, E3);
    bus.p_req = 0;
    tick(); tick(); tick();
    chk_valids("t3_d_valid", 3'b010);
    bus.d_req = 0;
    tick(); tick(); tick();
    chk_valids("t3_i_valid", 3'b100);
    bus.i_req = 0;
    tick();

    // tlb_write during a TLBP response does not suppress it
    bus.p_req = 1; bus.p_vpn2 = 19'h00777;
    tick(); tick();
    bus.tlb_write = 1;
    #1;
    chk_valids("t4a_p_valid_with_write", 3'b001);
    bus.p_req = 0;
    tick();
    bus.tlb_write = 0;
    chk("t4a_flush", {63'b0, bus.flush_ubuf}, 64'd1);

    // tlb_write in IDLE blocks the grant for that cycle
    bus.i_req = 1; bus.i_vpn2 = 19'h12345; bus.tlb_write = 1;
    tick();
    bus.tlb_write = 0;
    chk("t4b_no_grant", {63'b0, bus.busy}, 64'd0);
    chk("t4b_flush", {63'b0, bus.flush_ubuf}, 64'd1);
    tick();
    chk("t4b_grant_busy", {63'b0, bus.busy}, 64'd1);
    chk("t4b_flush_single", {63'b0, bus.flush_ubuf}, 64'd0);
    tick();
    chk_valids("t4b_i_valid", 3'b100);
    bus.i_req = 0;
    tick();

    // tlb_write in RESP of an I search suppresses the response
    bus.i_req = 1; bus.i_vpn2 = 19'h12345;
    tick(); tick();
    bus.tlb_write = 1;
    #1;
    chk_valids("t4c_suppressed", 3'b000);
    tick();
    bus.tlb_write = 0;
    chk("t4c_idle", {63'b0, bus.busy}, 64'd0);
    chk("t4c_flush", {63'b0, bus.flush_ubuf}, 64'd1);
    tick(); tick();
    chk_valids("t4c_i_retry_valid", 3'b100);
    bus.i_req = 0;
    tick();

    // tlb_write during SEARCH of a D request: re-searched against new entry
    bus.d_req = 1; bus.d_vpn2 = 19'h0ABCD;
    tick();
    bus.tlb_write = 1;
    tb_ent[9] = E9B;
    #1;
    chk_valids("t4d_c1_valids", 3'b000);
    tick();
    bus.tlb_write = 0;
    chk("t4d_c2_idle", {63'b0, bus.busy}, 64'd0);
    chk("t4d_c2_flush", {63'b0, bus.flush_ubuf}, 64'd1);
    chk_valids("t4d_c2_valids", 3'b000);
    tick();
    chk("t4d_c3_busy", {63'b0, bus.busy}, 64'd1);
    chk("t4d_c3_flush", {63'b0, bus.flush_ubuf}, 64'd0);
    tick();
    chk_valids("t4d_c4_valid", 3'b010);
    chk("t4d_c4_entry", bus.rsp_entry, E9B);
    chk("t4d_c4_index", {60'b0, bus.rsp_index}, 64'd9);
    bus.d_req = 0;
    tick();

    // Reset in SEARCH discards the pending response
    bus.i_req = 1; bus.i_vpn2 = 19'h12345;
    tick();
    chk("t6_c1_busy", {63'b0, bus.busy}, 64'd1);
    rst = 1; bus.i_req = 0;
    tick();
    chk("t6_busy", {63'b0, bus.busy}, 64'd0);
    chk_valids("t6_valids", 3'b000);
    chk("t6_found", {63'b0, bus.rsp_found}, 64'd0);
    chk("t6_index", {60'b0, bus.rsp_index}, 64'd0);
    chk("t6_flush", {63'b0, bus.flush_ubuf}, 64'd0);
    chk("t6_s_vpn2", {45'b0, bus.s_vpn2}, 64'd0);
    rst = 0;
    tick();

    // D-side miss
    bus.d_req = 1; bus.d_vpn2 = 19'h55555;
    tick(); tick();
    chk_valids("t5_d_valid", 3'b010);
    chk("t5_found", {63'b0, bus.rsp_found}, 64'd0);
    chk("t5_entry", bus.rsp_entry, 64'd0);
    bus.d_req = 0;
    tick();
    chk("t5_busy", {63'b0, bus.busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_search_arbiter.md
Name: tlb_search_arbiter

Overview:
- Shares the single search port of the main (joint) TLB between three requesters: I-side micro-TLB miss, D-side micro-TLB miss, and the CP0 TLBP instruction.
- Sits between the I/D micro-TLB buffers (PRE_IF / MEM stages) and the TLB array.
- Sequences one search at a time, registers the result and returns it to the owner.
- Turns TLB writes (TLBWI/TLBWR) into micro-buffer flush pulses and cancels any in-flight search.

Parameters:
- VPN2_W, 19, virtual page-pair number width (VA[31:13]).
- ASID_W, 8, address-space ID width.
- IDX_W, 4, TLB index width (16 entries).
- ENTRY_W, 64, flattened TLB_Entry width (ASID, G, PFN0/1, C0/1, D0/1, V0/1).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- i_req, in, 1, I-side search request; level, held until i_rsp_valid.
- i_vpn2, in, VPN2_W, I-side VPN2; stable while i_req=1.
- i_rsp_valid, out, 1, one-cycle pulse: result belongs to I-side.
- d_req, in, 1, D-side search request; same rules as i_req.
- d_vpn2, in, VPN2_W, D-side VPN2.
- d_rsp_valid, out, 1, one-cycle pulse: result belongs to D-side.
- p_req, in, 1, TLBP request from CP0.
- p_vpn2, in, VPN2_W, EntryHi.VPN2.
- p_rsp_valid, out, 1, one-cycle pulse: TLBP result.
- cp0_asid, in, ASID_W, current EntryHi.ASID.
- tlb_write, in, 1, TLBWI/TLBWR commit this cycle.
- s_vpn2, out, VPN2_W, search VPN2 to the TLB array.
- s_asid, out, ASID_W, search ASID to the TLB array.
- s_found, in, 1, combinational hit from the TLB array.
- s_index, in, IDX_W, hit index.
- s_entry, in, ENTRY_W, hit entry.
- rsp_found, out, 1, registered s_found.
- rsp_index, out, IDX_W, registered s_index.
- rsp_entry, out, ENTRY_W, registered s_entry.
- flush_ubuf, out, 1, one-cycle pulse that clears both micro-TLB buffers.
- busy, out, 1, state != IDLE.

Behaviour:
- States:
  - IDLE: selects a winner among asserted requests. p_req has highest priority; D over I (see Optional Feature). Latches the owner ID and the winner's VPN2, then goes to SEARCH. With no request it stays in IDLE.
  - SEARCH: s_vpn2 and s_asid are driven from the latched registers. At the clock edge, s_found, s_index and s_entry are captured into the rsp_* registers. Next state is RESP.
  - RESP: the owner's *_rsp_valid is high for exactly this cycle. Next state is IDLE.
- Latency: a request seen in IDLE at cycle 0 gets its rsp_valid in cycle 2. Back-to-back service costs 3 cycles per search.
- The requester drops req in the cycle after rsp_valid. The arbiter never re-grants the same owner in the cycle following RESP, because it must pass through IDLE, and req has already been sampled low by then.
- s_asid is cp0_asid, sampled at grant.
- s_vpn2 and s_asid hold their last value in IDLE and RESP.
- tlb_write:
  - flush_ubuf pulses in the next cycle. A single pulse is produced per tlb_write cycle.
  - If the state is SEARCH or RESP and the owner is I or D: no rsp_valid is produced (suppressed in the same cycle), and the state returns to IDLE. The requester still holds req and is re-searched against the updated TLB.
  - If the owner is P, the result is delivered normally; CP0 serializes TLBP against TLBW.
  - tlb_write in IDLE with requests pending: no grant that cycle.
- Only one *_rsp_valid is ever high at a time.
- rsp_* registers keep their value until the next capture.
- Reset (any state, including mid-search): state=IDLE; all *_rsp_valid=0; flush_ubuf=0; busy=0; rsp_found=0; rsp_index=0; rsp_entry=0; s_vpn2=0; s_asid=0; owner=I; rr pointer=I. A pending response is discarded.

Optional Feature:
- Macro TLB_ARB_RR_EN.
- Defined: a round-robin pointer between I and D, updated only when an I/D search completes with rsp_valid. The loser of the last I/D contention wins next. p_req still has absolute priority.
- Undefined: fixed priority P > D > I, and no pointer register exists.

Decomposition:
- Shared package (tlb_pkg):
  - enum tlb_arb_state_e {IDLE, SEARCH, RESP}.
  - enum tlb_owner_e {OWN_I, OWN_D, OWN_P}.
  - VPN2_W, ASID_W and IDX_W constants.
  - The existing TLB_Entry struct and its width.
- Sub-module tlb_arb_pick: a combinational winner select plus the rr pointer flop. It is small but isolates the macro-dependent logic.

Test Plan:
- i_req=1 alone with i_vpn2=0x12345 and a TLB hit at index 5 -> s_vpn2=0x12345 in cycle 1; i_rsp_valid=1 with rsp_found=1 and rsp_index=5 in cycle 2; busy=0 in cycle 3.
- i_req and d_req both asserted in the same cycle, with TLB_ARB_RR_EN defined -> D served first (rsp at cycle 2), then I (rsp at cycle 5). Repeat contention -> I first. Without the macro -> D first on both rounds.
- p_req, d_req and i_req all asserted -> p_rsp_valid at cycle 2, then D and I follow; never two rsp_valid in one cycle.
- tlb_write during SEARCH of a D request -> no d_rsp_valid; flush_ubuf=1 next cycle; D re-searched and rsp_valid delivered with the new entry.
- Miss: d_req with s_found=0 -> d_rsp_valid=1 and rsp_found=0.
- rst asserted in SEARCH -> next cycle state IDLE; no rsp_valid; rsp_found=0; flush_ubuf=0.
